// File: rtl/host_bus_master_if.sv
// host_bus_master_if: command/response and device bus signals of host_bus_master.
interface host_bus_master_if #(
   parameter int DW = 16,
   parameter int AW = 7
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic [DW-1:0] cmd_mask;
   logic          cmd_last;
   logic          CSB;
   logic          WRB;
   logic [AW:0]   CA;
   logic [DW-1:0] CD_in;
   logic [DW-1:0] CD_out;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [7:0]    err_cnt;
   logic          init_end;
   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_last, CD_out,
      output cmd_ready, CSB, WRB, CA, CD_in, rsp_valid, rsp_data, rsp_err, err_cnt, init_end
   );
   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_last, CD_out,
      input  cmd_ready, CSB, WRB, CA, CD_in, rsp_valid, rsp_data, rsp_err, err_cnt, init_end
   );
endinterface

// File: rtl/host_bus_master.sv
// host_bus_master: queued write/read/read-compare commands executed as timed CSB/WRB device accesses.
module host_bus_master #(
   parameter int DW         = 16,
   parameter int AW         = 7,
   parameter int DEPTH      = 8,
   parameter int STROBE_CYC = 2,
   parameter int RECOV_CYC  = 2
) (
   input logic Clk_reg,
   input logic Reset,
   host_bus_master_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2((STROBE_CYC > RECOV_CYC ? STROBE_CYC : RECOV_CYC) + 1);
   localparam logic [CW-1:0] S_END = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] R_END = CW'(RECOV_CYC - 1);
   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] mask;
      logic          last;
   } cmd_t;
   typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER} state_t;
   cmd_t          mem [DEPTH];
   cmd_t          head;
   state_t        state;
   logic [PW:0]   wr_ptr, rd_ptr, count;
   logic [CW-1:0] cnt;
   logic [1:0]    cur_op;
   logic [DW-1:0] cur_data, cur_mask;
   logic          cur_last, cur_rd, head_rd, push, pop, empty, full, mis, rec_end;
   assign count         = wr_ptr - rd_ptr;
   assign empty         = count == '0;
   assign full          = count == (PW+1)'(DEPTH);
   assign bus.cmd_ready = !full;
   assign push          = bus.cmd_valid && !full;
   assign rec_end       = state == RECOVER && cnt == R_END;
   assign pop           = !empty && (state == IDLE || rec_end);
   assign head          = mem[rd_ptr[PW-1:0]];
   assign head_rd       = head.op == 2'b01 || head.op == 2'b10;
   assign cur_rd        = cur_op == 2'b01 || cur_op == 2'b10;
   assign mis           = cur_op == 2'b10 && |((bus.CD_out ^ cur_data) & cur_mask);
   always_ff @(posedge Clk_reg)
      if (push) mem[wr_ptr[PW-1:0]] <= {bus.cmd_op, bus.cmd_addr, bus.cmd_data, bus.cmd_mask, bus.cmd_last};
   always_ff @(posedge Clk_reg or negedge Reset)
      if (!Reset) begin
         state         <= IDLE;
         cnt           <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cur_op        <= '0;
         cur_data      <= '0;
         cur_mask      <= '0;
         cur_last      <= 1'b0;
         bus.CSB       <= 1'b1;
         bus.WRB       <= 1'b1;
         bus.CA        <= '0;
         bus.CD_in     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
         bus.err_cnt   <= '0;
         bus.init_end  <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         if (push) begin
            wr_ptr       <= wr_ptr + 1'b1;
            bus.init_end <= 1'b0;
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            state     <= ACTIVE;
            cnt       <= '0;
            cur_op    <= head.op;
            cur_data  <= head.data;
            cur_mask  <= head.mask;
            cur_last  <= head.last;
            bus.CSB   <= 1'b0;
            bus.WRB   <= head_rd;
            bus.CA    <= {head.addr, 1'b0};
            bus.CD_in <= head_rd ? '0 : head.data;
         end else if (state == ACTIVE && cnt == S_END) begin
            state     <= RECOVER;
            cnt       <= '0;
            bus.CSB   <= 1'b1;
            bus.WRB   <= 1'b1;
            bus.CA    <= '0;
            bus.CD_in <= '0;
            if (cur_rd) begin
               bus.rsp_valid <= 1'b1;
               bus.rsp_data  <= bus.CD_out;
               bus.rsp_err   <= mis;
               if (mis && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 1'b1;
            end
         end else if (rec_end) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (state != IDLE) cnt <= cnt + 1'b1;
         // completion flag set overrides the clear from a same-edge push
         if (rec_end && cur_last) bus.init_end <= 1'b1;
      end
endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master: random and directed commands checked against a queue/timing reference model.
module tb_host_bus_master;
   typedef struct {
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [15:0] data;
      logic [15:0] mask;
      logic        last;
      int          s;
   } cmd_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   host_bus_master_if #(.DW(16), .AW(7)) bus ();
   host_bus_master dut (.Clk_reg(clk), .Reset(rst_n), .bus(bus));
   cmd_t        pend[$];
   cmd_t        cur;
   bit          have_cur, m_init, m_rv, m_re;
   logic [15:0] m_rd;
   int          m_cnt, e, total, bad, dut_full;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
      end
   endtask
   task automatic model_reset();
      pend.delete();
      have_cur = 0;
      m_init   = 0;
      m_rv     = 0;
      m_re     = 0;
      m_rd     = '0;
      m_cnt    = 0;
   endtask
   task automatic check_outputs();
      bit act, rd;
      act = have_cur && e < cur.s + 2;
      rd  = cur.op == 2'd1 || cur.op == 2'd2;
      if (bus.cmd_ready === 1'b0) dut_full++;
      check("csb", 32'(bus.CSB), 32'(!act));
      check("wrb", 32'(bus.WRB), 32'(act ? rd : 1'b1));
      check("ca", 32'(bus.CA), act ? 32'({cur.addr, 1'b0}) : 32'd0);
      check("cd_in", 32'(bus.CD_in), (act && !rd) ? 32'(cur.data) : 32'd0);
      check("cmd_ready", 32'(bus.cmd_ready), 32'(pend.size() < 8));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
      if (m_rv) begin
         check("rsp_data", 32'(bus.rsp_data), 32'(m_rd));
         check("rsp_err", 32'(bus.rsp_err), 32'(m_re));
      end
      check("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
      check("init_end", 32'(bus.init_end), 32'(m_init));
   endtask
   // one clock: drive at negedge, advance the model at the edge, check at the next negedge
   task automatic cycle(input bit v, input cmd_t c, input logic [15:0] cd, output bit acc);
      acc           = v && pend.size() < 8;
      bus.cmd_valid = v;
      bus.cmd_op    = c.op;
      bus.cmd_addr  = c.addr;
      bus.cmd_data  = c.data;
      bus.cmd_mask  = c.mask;
      bus.cmd_last  = c.last;
      bus.CD_out    = cd;
      @(posedge clk);
      e++;
      m_rv = 0;
      m_re = 0;
      if (have_cur && e == cur.s + 2 && (cur.op == 2'd1 || cur.op == 2'd2)) begin
         m_rv = 1;
         m_rd = cd;
         m_re = cur.op == 2'd2 && ((cd ^ cur.data) & cur.mask) != 16'd0;
         if (m_re && m_cnt < 255) m_cnt++;
      end
      if (acc) m_init = 0;
      if (have_cur && e == cur.s + 4) begin
         if (cur.last) m_init = 1;
         have_cur = 0;
      end
      if (!have_cur && pend.size() > 0) begin
         cur      = pend.pop_front();
         cur.s    = e;
         have_cur = 1;
      end
      if (acc) pend.push_back(c);
      @(negedge clk);
      check_outputs();
   endtask
   task automatic idle(input int n);
      cmd_t c;
      bit acc;
      c = '{2'd0, 7'd0, 16'd0, 16'd0, 1'b0, 0};
      for (int i = 0; i < n; i++) cycle(1'b0, c, 16'($urandom), acc);
   endtask
   task automatic offer(input logic [1:0] op, input logic [6:0] addr, input logic [15:0] data,
                        input logic [15:0] mask, input bit last, input logic [15:0] cd);
      cmd_t c;
      bit acc;
      acc = 0;
      c   = '{op, addr, data, mask, last, 0};
      for (int i = 0; i < 64 && !acc; i++) cycle(1'b1, c, cd, acc);
      check("offer_accepted", 32'(acc), 32'd1);
   endtask
   initial begin
      cmd_t c;
      bit acc, found;
      cur = '{2'd0, 7'd0, 16'd0, 16'd0, 1'b0, 0};
      bus.cmd_valid = 0;
      bus.cmd_op    = '0;
      bus.cmd_addr  = '0;
      bus.cmd_data  = '0;
      bus.cmd_mask  = '0;
      bus.cmd_last  = 0;
      bus.CD_out    = '0;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      offer(2'd0, 7'h05, 16'hA5A5, 16'h0000, 1'b0, 16'h0000);
      idle(6);
      offer(2'd2, 7'h10, 16'h1234, 16'hFF00, 1'b0, 16'h12FF);
      for (int i = 0; i < 6; i++) cycle(1'b0, c, 16'h12FF, acc);
      check("rc_match_err_cnt", 32'(bus.err_cnt), 32'd0);
      offer(2'd2, 7'h10, 16'h1234, 16'hFF00, 1'b0, 16'h13FF);
      for (int i = 0; i < 6; i++) cycle(1'b0, c, 16'h13FF, acc);
      check("rc_miss_err_cnt", 32'(bus.err_cnt), 32'd1);
      offer(2'd3, 7'h7F, 16'hBEEF, 16'h0000, 1'b0, 16'h0000);
      offer(2'd1, 7'h22, 16'h0000, 16'h0000, 1'b0, 16'h5A5A);
      idle(10);
      dut_full = 0;
      for (int i = 0; i < 14; i++) offer(2'($urandom), 7'($urandom), 16'($urandom), 16'($urandom), 1'b0, 16'($urandom));
      check("fifo_full_seen", 32'(dut_full > 0), 32'd1);
      idle(70);
      offer(2'd0, 7'h01, 16'h1111, 16'h0, 1'b0, 16'h0);
      offer(2'd0, 7'h02, 16'h2222, 16'h0, 1'b0, 16'h0);
      offer(2'd0, 7'h03, 16'h3333, 16'h0, 1'b1, 16'h0);
      idle(14);
      check("init_end_held", 32'(bus.init_end), 32'd1);
      offer(2'd0, 7'h04, 16'h4444, 16'h0, 1'b0, 16'h0);
      check("init_end_cleared", 32'(bus.init_end), 32'd0);
      idle(8);
      for (int i = 0; i < 300; i++) begin
         c.op   = 2'($urandom);
         c.addr = 7'($urandom);
         c.data = 16'($urandom);
         c.mask = 16'($urandom);
         c.last = ($urandom % 8) == 0;
         c.s    = 0;
         cycle(1'($urandom), c, 16'($urandom), acc);
      end
      idle(40);
      offer(2'd0, 7'h0A, 16'hCAFE, 16'h0, 1'b0, 16'h0);
      offer(2'd1, 7'h0B, 16'h0, 16'h0, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++) offer(2'd0, 7'(i), 16'(i), 16'h0, 1'b0, 16'h0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (have_cur && cur.op == 2'd1 && e == cur.s) found = 1;
         else idle(1);
      end
      check("reset_window_found", 32'(found), 32'd1);
      check("queued_before_reset", 32'(pend.size()), 32'd3);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_outputs();
      @(negedge clk);
      e++;
      rst_n = 1'b1;
      idle(12);
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) offer(2'd2, 7'($urandom), 16'h0000, 16'hFFFF, 1'b0, 16'($urandom_range(1, 65535)));
      idle(10);
      check("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
